// File: rtl/serial_logic_unit.sv
// serial_logic_unit
//   Bit-serial logic/arithmetic unit. It processes WIDTH-bit operands one bit
//   per clock, LSB first. The selectable ops are XOR, OR, AND, and ADD; for
//   ADD the ripple carry is held in a flop between bits.
//
//   Ports
//     clk        rising-edge clock
//     rst_n      asynchronous active-low reset
//     start      request, sampled only in IDLE
//     op         00 XOR, 01 OR, 10 AND, 11 ADD (sampled with start)
//     a, b       operands (sampled with start)
//     busy       high while bits are being processed
//     done       one-cycle pulse when result/carry_out update
//     result     last completed result, held until the next completion
//     carry_out  final carry of the last ADD, 0 for the other ops
//
//   state  | meaning
//   IDLE   | waiting for start; operands not yet captured
//   RUN    | one operand bit processed per edge, LSB first
//   DONE   | result/carry_out just loaded, done pulse high
module serial_logic_unit #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result,
   output logic             carry_out
);

   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [1:0] OP_XOR = 2'b00;
   localparam logic [1:0] OP_OR  = 2'b01;
   localparam logic [1:0] OP_AND = 2'b10;
   localparam logic [1:0] OP_ADD = 2'b11;

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

   state_t           state;
   logic [WIDTH-1:0] a_sh;
   logic [WIDTH-1:0] b_sh;
   logic [WIDTH-1:0] partial;
   logic [WIDTH-1:0] partial_next;
   logic [1:0]       op_reg;
   logic [CW-1:0]    cnt;
   logic             carry;
   logic             carry_next;
   logic             bit_val;
   logic             ai;
   logic             bi;

   // The current bit always sits at position 0 of the shifted operands. Result
   // bits enter at the MSB, so after WIDTH shifts they are in place.
   always_comb begin
      ai           = a_sh[0];
      bi           = b_sh[0];
      bit_val      = 1'b0;
      carry_next   = carry;
      partial_next = partial >> 1;
      case (op_reg)
         OP_XOR: bit_val = ai ^ bi;
         OP_OR:  bit_val = ai | bi;
         OP_AND: bit_val = ai & bi;
         OP_ADD: begin
            bit_val    = ai ^ bi ^ carry;
            carry_next = (ai & bi) | (carry & (ai ^ bi));
         end
         default: bit_val = 1'b0;
      endcase
      partial_next[WIDTH-1] = bit_val;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= S_IDLE;
         a_sh      <= '0;
         b_sh      <= '0;
         partial   <= '0;
         op_reg    <= OP_XOR;
         cnt       <= '0;
         carry     <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
         result    <= '0;
         carry_out <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               done <= 1'b0;
               if (start) begin
                  a_sh    <= a;
                  b_sh    <= b;
                  op_reg  <= op;
                  carry   <= 1'b0;
                  cnt     <= '0;
                  partial <= '0;
                  busy    <= 1'b1;
                  state   <= S_RUN;
               end
            end
            S_RUN: begin
               a_sh    <= a_sh >> 1;
               b_sh    <= b_sh >> 1;
               partial <= partial_next;
               carry   <= carry_next;
               if (cnt == CW'(WIDTH - 1)) begin
                  // The final bit is folded into result directly, so the
                  // result is visible in the same cycle that done is high.
                  result    <= partial_next;
                  carry_out <= (op_reg == OP_ADD) ? carry_next : 1'b0;
                  busy      <= 1'b0;
                  done      <= 1'b1;
                  state     <= S_DONE;
               end else begin
                  cnt <= cnt + CW'(1);
               end
            end
            S_DONE: begin
               done  <= 1'b0;
               state <= S_IDLE;
            end
            default: begin
               busy  <= 1'b0;
               done  <= 1'b0;
               state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_serial_logic_unit.sv
module tb_serial_logic_unit;

   typedef struct {
      logic [7:0] r;
      logic       c;
      int         cyc;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst_n;
   int         cyc = 0;
   int         n_tests = 0;
   int         n_fail = 0;

   logic       start8, busy8, done8, carry8;
   logic [1:0] op8;
   logic [7:0] a8, b8, result8;

   logic       start1, busy1, done1, carry1;
   logic [1:0] op1;
   logic [0:0] a1, b1, result1;

   exp_t q8[$];
   exp_t q1[$];
   int   busy_n8 = 0;
   int   busy_n1 = 0;

   serial_logic_unit #(.WIDTH(8)) dut8 (
      .clk(clk), .rst_n(rst_n), .start(start8), .op(op8), .a(a8), .b(b8),
      .busy(busy8), .done(done8), .result(result8), .carry_out(carry8)
   );

   serial_logic_unit #(.WIDTH(1)) dut1 (
      .clk(clk), .rst_n(rst_n), .start(start1), .op(op1), .a(a1), .b(b1),
      .busy(busy1), .done(done1), .result(result1), .carry_out(carry1)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input int act, input int exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Scoreboard monitors: one per instance, popping on every done pulse.
   always @(negedge clk) begin
      exp_t e;
      if (!rst_n) busy_n8 = 0;
      else if (done8) begin
         if (q8.size() == 0) chk("w8_unexpected_done", 1, 0);
         else begin
            e = q8.pop_front();
            chk("w8_result", int'(result8), int'(e.r));
            chk("w8_carry", int'(carry8), int'(e.c));
            chk("w8_done_cycle", cyc, e.cyc);
            chk("w8_busy_cycles", busy_n8, 8);
            chk("w8_busy_with_done", int'(busy8), 0);
         end
         busy_n8 = 0;
      end else if (busy8) busy_n8++;
   end

   always @(negedge clk) begin
      exp_t e;
      if (!rst_n) busy_n1 = 0;
      else if (done1) begin
         if (q1.size() == 0) chk("w1_unexpected_done", 1, 0);
         else begin
            e = q1.pop_front();
            chk("w1_result", int'(result1), int'(e.r));
            chk("w1_carry", int'(carry1), int'(e.c));
            chk("w1_done_cycle", cyc, e.cyc);
            chk("w1_busy_cycles", busy_n1, 1);
            chk("w1_busy_with_done", int'(busy1), 0);
         end
         busy_n1 = 0;
      end else if (busy1) busy_n1++;
   end

   task automatic go8(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b,
                      input logic [7:0] r, input logic c, input bit expect_done);
      exp_t e;
      @(posedge clk); #1;
      op8 = op; a8 = a; b8 = b; start8 = 1'b1;
      if (expect_done) begin
         e.r = r; e.c = c; e.cyc = cyc + 9;
         q8.push_back(e);
      end
      @(posedge clk); #1;
      start8 = 1'b0;
   endtask

   task automatic go1(input logic [1:0] op, input logic a, input logic b,
                      input logic r, input logic c);
      exp_t e;
      @(posedge clk); #1;
      op1 = op; a1 = a; b1 = b; start1 = 1'b1;
      e.r = {7'd0, r}; e.c = c; e.cyc = cyc + 2;
      q1.push_back(e);
      @(posedge clk); #1;
      start1 = 1'b0;
   endtask

   task automatic wait_done8();
      int t = 0;
      while (!done8 && t < 40) begin @(negedge clk); t++; end
      if (!done8) chk("w8_done_timeout", 0, 1);
   endtask

   task automatic wait_done1();
      int t = 0;
      while (!done1 && t < 20) begin @(negedge clk); t++; end
      if (!done1) chk("w1_done_timeout", 0, 1);
   endtask

   initial begin
      rst_n = 1'b0;
      start8 = 1'b0; op8 = 2'b00; a8 = '0; b8 = '0;
      start1 = 1'b0; op1 = 2'b00; a1 = '0; b1 = '0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_busy", int'(busy8), 0);
      chk("rst_done", int'(done8), 0);
      chk("rst_result", int'(result8), 0);
      chk("rst_carry", int'(carry8), 0);
      rst_n = 1'b1;

      // XOR, then OR/AND back-to-back
      go8(2'b00, 8'hA5, 8'h3C, 8'h99, 1'b0, 1'b1); wait_done8();
      go8(2'b01, 8'hA5, 8'h3C, 8'hBD, 1'b0, 1'b1); wait_done8();
      go8(2'b10, 8'hA5, 8'h3C, 8'h24, 1'b0, 1'b1); wait_done8();

      // ADD with and without overflow
      go8(2'b11, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b1); wait_done8();
      go8(2'b11, 8'hA5, 8'h3C, 8'hE1, 1'b0, 1'b1); wait_done8();
      go8(2'b11, 8'h80, 8'h80, 8'h00, 1'b1, 1'b1); wait_done8();
      go8(2'b10, 8'hFF, 8'h0F, 8'h0F, 1'b0, 1'b1); wait_done8();

      // start and operands changed during RUN: ignored
      go8(2'b00, 8'h0F, 8'hF0, 8'hFF, 1'b0, 1'b1);
      repeat (2) @(posedge clk);
      #1; start8 = 1'b1; op8 = 2'b11; a8 = 8'h11; b8 = 8'h22;
      @(posedge clk); #1; start8 = 1'b0;
      wait_done8();
      repeat (15) @(posedge clk);

      // leave a nonzero result/carry before the reset test
      go8(2'b11, 8'hFF, 8'hFF, 8'hFE, 1'b1, 1'b1); wait_done8();

      // reset during RUN cycle 4
      go8(2'b11, 8'h12, 8'h34, 8'h00, 1'b0, 1'b0);
      repeat (3) @(posedge clk);
      #1; rst_n = 1'b0;
      #1;
      chk("midrst_busy", int'(busy8), 0);
      chk("midrst_done", int'(done8), 0);
      chk("midrst_result", int'(result8), 0);
      chk("midrst_carry", int'(carry8), 0);
      @(posedge clk); #1; rst_n = 1'b1;
      repeat (12) @(posedge clk);
      #1;
      chk("postrst_busy", int'(busy8), 0);
      chk("postrst_result", int'(result8), 0);
      go8(2'b10, 8'hF0, 8'h3C, 8'h30, 1'b0, 1'b1); wait_done8();

      // WIDTH=1 half-adder and XOR truth table
      for (int i = 0; i < 4; i++) begin
         logic x, y;
         x = i[1]; y = i[0];
         go1(2'b11, x, y, x ^ y, x & y); wait_done1();
         go1(2'b00, x, y, x ^ y, 1'b0); wait_done1();
      end

      repeat (5) @(posedge clk);
      chk("w8_queue_empty", q8.size(), 0);
      chk("w1_queue_empty", q1.size(), 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1);
   end

endmodule
